test_i3702_core: RTL and testbench
==================================

TEST_I3702_CORE -- requirements
Module: test_I3702

Interface
REQ-001 SHALL have port CK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port N0, input, 1 bit: primary input 0 (G0).
REQ-004 SHALL have port N1, input, 1 bit: primary input 1 (G1).
REQ-005 SHALL have port N2, input, 1 bit: primary input 2 (G2).
REQ-006 SHALL have port N3, input, 1 bit: primary input 3 (G3).
REQ-007 SHALL have port Q, output, 1 bit: primary output (G17).
REQ-008 SHALL use positional port order N0, N1, N2, N3, CK, reset, Q.
REQ-009 SHALL have no parameters; all widths are fixed at 1 bit.

Function
REQ-010 SHALL hold three 1-bit state flops: S5 (G5), S6 (G6) and S7 (G7).
REQ-011 SHALL compute the following combinational nets, with no extra pipelining:
- G14 = NOT N0
- G12 = NOR(N1, S7)
- G8 = AND(G14, S6)
- G15 = OR(G12, G8)
- G16 = OR(N3, G8)
- G9 = NAND(G16, G15)
- G11 = NOR(S5, G9)
- G10 = NOR(G14, G11)
- G13 = NOR(N2, G12)
REQ-012 SHALL drive Q = NOT G11 combinationally from the current inputs and state (Mealy; zero-cycle latency from inputs to Q).
REQ-013 SHALL load the next state on each rising CK edge: S5 <= G10, S6 <= G11, S7 <= G13.
REQ-014 SHALL contain no combinational loops; each net depends only on inputs and flop outputs.
REQ-015 SHALL update the state every cycle, with no enable and no handshake.
REQ-016 SHALL give reset precedence over a simultaneous rising CK edge.

Reset
REQ-017 SHALL force S5 = S6 = S7 = 0 immediately when reset goes high, without waiting for a clock edge.
REQ-018 SHALL hold the state at 000 for as long as reset is high.
REQ-019 SHALL give Q = 1 while in reset with inputs 0000, because Q follows the combinational equation.
REQ-020 SHALL resume state updates on the first rising CK edge after reset is released.
REQ-021 SHALL, when reset is asserted mid-operation, clear any state immediately, and Q SHALL re-evaluate accordingly.

Structure
REQ-022 SHALL use a shared package containing:
- state width constant STATE_W = 3
- reset state constant RST_STATE = 3'b000
- a packed typedef for the state vector {S5, S6, S7}
REQ-023 SHALL place the combinational next-state/output logic in one sub-module, s27_logic, with inputs N0..N3 and state, and outputs next_state and Q.
REQ-024 SHALL keep the top level limited to the asynchronously reset state register plus the s27_logic instance.

Verification
REQ-025 SHALL pass: reset, then N=0000 for several cycles -> Q=1 throughout, state stays 000.
REQ-026 SHALL pass: from state 000, N=0001 -> Q=0 in the same cycle; after the edge, state = 010 (S6=1); then N=0000 -> Q=0.
REQ-027 SHALL pass: from state 000, N=1000 -> Q=1; after the edge, S5=1; holding N=1000 -> Q stays 1 and S5 stays 1.
REQ-028 SHALL pass: from state 000, N=0100 -> Q=1; after the edge, state = 001 (S7=1).
REQ-029 SHALL pass: in state 010, assert reset asynchronously between clock edges -> state = 000 at once, and with N=0000, Q goes from 0 to 1 without a clock edge.
REQ-030 SHALL pass: a sweep of all 16 N values, one per cycle (0000..1111), with Q compared every cycle against a cycle-accurate reference model built from the REQ-011 to REQ-013 equations.

Source files
------------

// File: rtl/test_i3702_core_pkg.sv
// Shared types and constants for the s27-style sequential core.
// The state vector is ordered {S5, S6, S7}, matching the G5/G6/G7 flops.
package test_i3702_core_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] RST_STATE = 3'b000;

    typedef struct packed {
        logic s5;
        logic s6;
        logic s7;
    } state_t;

    // Reset value expressed in the packed state type.
    function automatic state_t reset_state();
        state_t st;
        st = state_t'(RST_STATE);
        return st;
    endfunction

endpackage

// File: rtl/test_i3702_core_s27_logic.sv
// Combinational next-state and Mealy output logic for the s27 core.
// Every net depends only on primary inputs and current flop outputs.
module s27_logic
    import test_i3702_core_pkg::*;
(
    input  logic   N0,
    input  logic   N1,
    input  logic   N2,
    input  logic   N3,
    input  state_t state,
    output state_t next_state,
    output logic   Q
);

    logic g8_s;
    logic g9_s;
    logic g10_s;
    logic g11_s;
    logic g12_s;
    logic g13_s;
    logic g14_s;
    logic g15_s;
    logic g16_s;

    // Gate network in dependency order; Q is a pure function of inputs and state.
    always_comb begin
        g14_s = ~N0;
        g12_s = ~(N1 | state.s7);
        g8_s  = g14_s & state.s6;
        g15_s = g12_s | g8_s;
        g16_s = N3 | g8_s;
        g9_s  = ~(g16_s & g15_s);
        g11_s = ~(state.s5 | g9_s);
        g10_s = ~(g14_s | g11_s);
        g13_s = ~(N2 | g12_s);

        next_state.s5 = g10_s;
        next_state.s6 = g11_s;
        next_state.s7 = g13_s;
        Q             = ~g11_s;
    end

endmodule

// File: rtl/test_i3702_core.sv
// Top of the s27 core: an asynchronously reset 3-bit state register
// feeding the combinational s27_logic block.
module test_i3702_core
    import test_i3702_core_pkg::*;
(
    input  logic N0,
    input  logic N1,
    input  logic N2,
    input  logic N3,
    input  logic CK,
    input  logic reset,
    output logic Q
);

    state_t state_r;
    state_t next_state_s;

    // State register; reset wins over a coincident clock edge.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_r <= reset_state();
        end else begin
            state_r <= next_state_s;
        end
    end

    s27_logic u_logic (
        .N0         (N0),
        .N1         (N1),
        .N2         (N2),
        .N3         (N3),
        .state      (state_r),
        .next_state (next_state_s),
        .Q          (Q)
    );

endmodule

// File: tb/tb_test_i3702_core.sv
// Self-checking bench: directed scenarios, a full input sweep and random
// stimulus with asynchronous resets, checked against a behavioural model.
module tb_test_i3702_core;

    logic CK;
    logic reset;
    logic N0;
    logic N1;
    logic N2;
    logic N3;
    logic Q;

    int n_checks;
    int n_fail;

    // Model state as {S5, S6, S7}; stimulus as {N0, N1, N2, N3}.
    logic [2:0] m_state;
    logic [3:0] cur_n;

    test_i3702_core dut (
        .N0    (N0),
        .N1    (N1),
        .N2    (N2),
        .N3    (N3),
        .CK    (CK),
        .reset (reset),
        .Q     (Q)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Simplified Boolean form: G11 = !S5 & (N3 | G8) & (G12 | G8).
    function automatic logic ref_g11(input logic [3:0] n, input logic [2:0] s);
        logic g8;
        logic g12;
        g8  = !n[3] && s[1];
        g12 = !(n[2] || s[0]);
        return !s[2] && (n[0] || g8) && (g12 || g8);
    endfunction

    function automatic logic ref_q(input logic [3:0] n, input logic [2:0] s);
        return !ref_g11(n, s);
    endfunction

    function automatic logic [2:0] ref_next(input logic [3:0] n, input logic [2:0] s);
        logic g11;
        logic [2:0] nx;
        g11   = ref_g11(n, s);
        nx[2] = n[3] && !g11;
        nx[1] = g11;
        nx[0] = !n[1] && (n[2] || s[0]);
        return nx;
    endfunction

    task automatic drive(input logic [3:0] n);
        cur_n = n;
        {N0, N1, N2, N3} = n;
    endtask

    // Called at a falling edge: apply n, check Q, clock once, check state.
    task automatic step(input string tag, input logic [3:0] n);
        drive(n);
        #1;
        check_eq({tag, "_q"}, {2'b00, Q}, {2'b00, ref_q(cur_n, m_state)});
        @(posedge CK);
        m_state = ref_next(cur_n, m_state);
        #1;
        check_eq({tag, "_state"}, dut.state_r, m_state);
        @(negedge CK);
    endtask

    // Called at a falling edge: assert reset between edges and check it acts at once.
    task automatic async_reset(input string tag);
        @(posedge CK);
        m_state = ref_next(cur_n, m_state);
        #2;
        reset = 1'b1;
        m_state = 3'b000;
        #1;
        check_eq({tag, "_rst_state"}, dut.state_r, 3'b000);
        check_eq({tag, "_rst_q"}, {2'b00, Q}, {2'b00, ref_q(cur_n, 3'b000)});
        @(negedge CK);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_state  = 3'b000;
        reset    = 1'b1;
        drive(4'b0000);

        // Reset held: state 000, Q = 1 with all-zero inputs.
        repeat (2) @(negedge CK);
        check_eq("in_reset_state", dut.state_r, 3'b000);
        check_eq("in_reset_q", {2'b00, Q}, 3'b001);
        @(posedge CK);
        #1;
        check_eq("in_reset_hold", dut.state_r, 3'b000);
        @(negedge CK);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            step("idle", 4'b0000);
            check_eq("idle_q_one", {2'b00, Q}, 3'b001);
            check_eq("idle_state_zero", dut.state_r, 3'b000);
        end

        // N3 alone: Q low immediately, then S6 set; Q stays low with zero inputs.
        drive(4'b0001);
        #1;
        check_eq("n3_q_now", {2'b00, Q}, 3'b000);
        step("n3", 4'b0001);
        check_eq("n3_state_010", dut.state_r, 3'b010);
        drive(4'b0000);
        #1;
        check_eq("n3_then_zero_q", {2'b00, Q}, 3'b000);
        step("n3_zero", 4'b0000);

        // Asynchronous reset out of state 010: Q rises without a clock edge.
        check_eq("pre_rst_state", dut.state_r, 3'b010);
        async_reset("mid");
        check_eq("mid_rst_q_high", {2'b00, Q}, 3'b001);

        // N0 alone: S5 set and held, Q stays high.
        step("n0_a", 4'b1000);
        check_eq("n0_s5_set", dut.state_r, 3'b100);
        step("n0_b", 4'b1000);
        check_eq("n0_q_hold", {2'b00, Q}, 3'b001);
        check_eq("n0_s5_hold", {2'b00, dut.state_r.s5}, 3'b001);

        // N1 alone from 000: S7 set.
        async_reset("pre_n1");
        drive(4'b0100);
        #1;
        check_eq("n1_q_now", {2'b00, Q}, 3'b001);
        step("n1", 4'b0100);
        check_eq("n1_state_001", dut.state_r, 3'b001);

        // Full sweep of N from the reset state, one value per cycle.
        async_reset("pre_sweep");
        for (int i = 0; i < 16; i++) begin
            step("sweep", 4'(i));
        end

        // Random stimulus with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                async_reset("rnd");
            end else begin
                step("rnd", 4'($urandom_range(0, 15)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
